// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG request arbiter.
// Holds the controller state encoding, data width, default timeout and a small index helper.
package prng_pkg;

    localparam int DATA_W          = 32;
    localparam int DEFAULT_TIMEOUT = 15;
    localparam int ID_W            = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RANGE = 3'd2,
        ST_GEN   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
        return (int'(v) == n - 1) ? '0 : v + ID_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Zero latency, no state; any=0 when no request is pending.
module rr_arbiter
    import prng_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (ID_W'(j) >= ptr)) begin
                any = 1'b1;
                idx = ID_W'(j);
            end
        end
        // Wrapped half: indices below the pointer.
        for (int j = 0; j < N; j++) begin
            if (!any && req[j]) begin
                any = 1'b1;
                idx = ID_W'(j);
            end
        end
        gnt = '0;
        for (int j = 0; j < N; j++) begin
            gnt[j] = any && (idx == ID_W'(j));
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Shares one xorshift32 PRNG among NUM_REQ requesters with reseed, range cache and timeout.
// gnt 4 cycles after IDLE sample on a range miss, 3 on a hit; requesters hold req until gnt.
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      prng_reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DATA_W*NUM_REQ-1:0] req_low,
    input  logic [DATA_W*NUM_REQ-1:0] req_high,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         rsp_raw,
    output logic                      rsp_err,
    input  logic                      seed_wr,
    input  logic [DATA_W-1:0]         seed_val,
    output logic                      seed_pending,
    output logic                      rng_enable,
    output logic                      rng_update_range,
    output logic [DATA_W-1:0]         rng_new_low,
    output logic [DATA_W-1:0]         rng_new_high,
    output logic                      rng_update_seed,
    output logic [DATA_W-1:0]         rng_new_seed,
    input  logic                      rng_valid,
    input  logic [DATA_W-1:0]         rng_raw,
    input  logic [DATA_W-1:0]         rng_in_range
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, win_q, win_d;
    logic [NUM_REQ-1:0]   win_oh_q, win_oh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cache_vld_q, cache_vld_d;
    logic [DATA_W-1:0]    cache_low_q, cache_low_d, cache_high_q, cache_high_d;
    logic [DATA_W-1:0]    seed_q, seed_d;
    logic                 seed_pending_q, seed_pending_d;

    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d, rsp_raw_q, rsp_raw_d;
    logic                 rng_enable_q, rng_enable_d;
    logic                 rng_update_range_q, rng_update_range_d;
    logic                 rng_update_seed_q, rng_update_seed_d;
    logic [DATA_W-1:0]    rng_new_low_q, rng_new_low_d, rng_new_high_q, rng_new_high_d;
    logic [DATA_W-1:0]    rng_new_seed_q, rng_new_seed_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]      arb_idx;
    logic                 arb_any;
    logic [DATA_W-1:0]    win_low, win_high;
    logic                 cache_hit, wait_expired;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        win_low  = '0;
        win_high = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_idx == ID_W'(j)) begin
                win_low  = req_low[DATA_W*j +: DATA_W];
                win_high = req_high[DATA_W*j +: DATA_W];
            end
        end
    end

    assign cache_hit    = cache_vld_q && (win_low == cache_low_q) && (win_high == cache_high_q);
    assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (prng_reset) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_pending_q) state_d = ST_SEED;
                else if (arb_any)   state_d = cache_hit ? ST_GEN : ST_RANGE;
            end
            ST_SEED:  state_d = ST_IDLE;
            ST_RANGE: state_d = ST_GEN;
            ST_GEN:   state_d = ST_WAIT;
            ST_WAIT:  if (rng_valid || wait_expired) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        win_oh_d     = win_oh_q;
        cnt_d        = cnt_q;
        cache_vld_d  = cache_vld_q;
        cache_low_d  = cache_low_q;
        cache_high_d = cache_high_q;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_RANGE || state_d == ST_GEN) begin
                    win_d    = arb_idx;
                    win_oh_d = arb_gnt;
                end
                if (state_d == ST_RANGE) begin
                    cache_vld_d  = 1'b1;
                    cache_low_d  = win_low;
                    cache_high_d = win_high;
                end
            end
            ST_GEN:  cnt_d = '0;
            ST_WAIT: cnt_d = cnt_q + CNT_W'(1);
            ST_RESP: rr_ptr_d = wrap_inc(win_q, NUM_REQ);
            default: ;
        endcase
        // A fresh strobe always wins, so a seed arriving as SEED starts stays pending.
        seed_d         = seed_q;
        seed_pending_d = seed_pending_q;
        if (seed_wr) begin
            seed_d         = seed_val;
            seed_pending_d = 1'b1;
        end else if (state_d == ST_SEED) begin
            seed_pending_d = 1'b0;
        end
    end

    always_comb begin
        rng_enable_d       = (state_d == ST_GEN);
        rng_update_range_d = (state_d == ST_RANGE);
        rng_update_seed_d  = (state_d == ST_SEED);
        rng_new_low_d      = rng_update_range_d ? win_low  : rng_new_low_q;
        rng_new_high_d     = rng_update_range_d ? win_high : rng_new_high_q;
        rng_new_seed_d     = rng_update_seed_d  ? seed_q   : rng_new_seed_q;
        rsp_valid_d        = (state_d == ST_RESP);
        gnt_d              = rsp_valid_d ? win_oh_q : '0;
        rsp_id_d           = rsp_valid_d ? win_q : '0;
        rsp_err_d          = rsp_valid_d && !rng_valid;
        rsp_data_d         = (rsp_valid_d && rng_valid) ? rng_in_range : '0;
        rsp_raw_d          = (rsp_valid_d && rng_valid) ? rng_raw : '0;
    end

    always_ff @(posedge clk) begin
        if (prng_reset) begin
            rr_ptr_q <= '0;  win_q <= '0;  win_oh_q <= '0;  cnt_q <= '0;
            cache_vld_q <= 1'b0;  cache_low_q <= '0;  cache_high_q <= '0;
            seed_q <= '0;  seed_pending_q <= 1'b0;
            gnt_q <= '0;  rsp_valid_q <= 1'b0;  rsp_id_q <= '0;  rsp_err_q <= 1'b0;
            rsp_data_q <= '0;  rsp_raw_q <= '0;
            rng_enable_q <= 1'b0;  rng_update_range_q <= 1'b0;  rng_update_seed_q <= 1'b0;
            rng_new_low_q <= '0;  rng_new_high_q <= '0;  rng_new_seed_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;  win_q <= win_d;  win_oh_q <= win_oh_d;  cnt_q <= cnt_d;
            cache_vld_q <= cache_vld_d;  cache_low_q <= cache_low_d;  cache_high_q <= cache_high_d;
            seed_q <= seed_d;  seed_pending_q <= seed_pending_d;
            gnt_q <= gnt_d;  rsp_valid_q <= rsp_valid_d;  rsp_id_q <= rsp_id_d;  rsp_err_q <= rsp_err_d;
            rsp_data_q <= rsp_data_d;  rsp_raw_q <= rsp_raw_d;
            rng_enable_q <= rng_enable_d;  rng_update_range_q <= rng_update_range_d;
            rng_update_seed_q <= rng_update_seed_d;
            rng_new_low_q <= rng_new_low_d;  rng_new_high_q <= rng_new_high_d;
            rng_new_seed_q <= rng_new_seed_d;
        end
    end

    assign gnt              = gnt_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = rsp_id_q;
    assign rsp_data         = rsp_data_q;
    assign rsp_raw          = rsp_raw_q;
    assign rsp_err          = rsp_err_q;
    assign seed_pending     = seed_pending_q;
    assign rng_enable       = rng_enable_q;
    assign rng_update_range = rng_update_range_q;
    assign rng_new_low      = rng_new_low_q;
    assign rng_new_high     = rng_new_high_q;
    assign rng_update_seed  = rng_update_seed_q;
    assign rng_new_seed     = rng_new_seed_q;

endmodule

// File: doc/prng_arbiter.md
PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one xorshift32_rng instance; legal values 2..8.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles before the transaction is aborted.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high. Ports clk and prng_reset.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 prng_reset  in  1  synchronous active-high reset.
REQ-006 req  in  NUM_REQ  per-requester level request; held until its gnt bit pulses.
REQ-007 req_low  in  32*NUM_REQ  per-requester range low bound, slice i = bits [32i+31:32i].
REQ-008 req_high  in  32*NUM_REQ  per-requester range high bound, exclusive; same slicing.
REQ-009 gnt  out  NUM_REQ  one-hot, one-cycle completion pulse.
REQ-010 rsp_valid  out  1  high in the same cycle as gnt.
REQ-011 rsp_id  out  3  index of the granted requester.
REQ-012 rsp_data  out  32  in-range random value.
REQ-013 rsp_raw  out  32  raw 32-bit value.
REQ-014 rsp_err  out  1  timeout flag; qualified by rsp_valid.
REQ-015 seed_wr  in  1  one-cycle reseed strobe.
REQ-016 seed_val  in  32  seed value captured with seed_wr.
REQ-017 seed_pending  out  1  a captured seed is not yet written.
REQ-018 rng_enable  out  1  PRNG enable pulse.
REQ-019 rng_update_range  out  1  PRNG range-load pulse.
REQ-020 rng_new_low  out  32  PRNG range low bound.
REQ-021 rng_new_high  out  32  PRNG range high bound.
REQ-022 rng_update_seed  out  1  PRNG seed-load pulse.
REQ-023 rng_new_seed  out  32  PRNG seed value.
REQ-024 rng_valid  in  1  PRNG output valid.
REQ-025 rng_raw  in  32  PRNG raw output.
REQ-026 rng_in_range  in  32  PRNG in-range output.

Function
REQ-027 FSM states: IDLE, SEED, RANGE, GEN, WAIT, RESP.
REQ-028 IDLE priority: seed_pending goes to SEED; otherwise any req bit goes to RANGE, or directly to GEN on a range-cache hit; otherwise stay in IDLE.
REQ-029 Winner selection: round-robin from pointer rr_ptr, registered in IDLE; after RESP, rr_ptr becomes winner+1 modulo NUM_REQ.
REQ-030 SEED: rng_update_seed=1 and rng_new_seed=captured seed for exactly one cycle; clear seed_pending; return to IDLE. Seed 0 passes through unchanged.
REQ-031 seed_wr in any state captures seed_val and sets seed_pending. A second seed_wr while pending overwrites the value.
REQ-032 RANGE: rng_update_range=1 for one cycle with the winner's low/high; load the range cache (low, high, valid=1); go to GEN. High<=low passes through unchanged.
REQ-033 Cache hit: cache valid, and winner low/high equal the cached values.
REQ-034 GEN: rng_enable=1 for one cycle; clear the timeout counter; go to WAIT.
REQ-035 WAIT, first cycle with rng_valid=1: capture rng_in_range and rng_raw; go to RESP with err=0.
REQ-036 WAIT, counter reaching TIMEOUT: go to RESP with err=1; data and raw are 0.
REQ-037 RESP: gnt[winner]=1, rsp_valid=1, rsp_id=winner, and registered data/raw/err for exactly one cycle; go to IDLE.
REQ-038 Latency from req sampled in IDLE (cycle 0) to gnt: cache miss at cycle 4, cache hit at cycle 3.
REQ-039 A requester dropping req mid-transaction does not abort it; gnt still pulses.
REQ-040 rng_enable, rng_update_range and rng_update_seed are mutually exclusive in every cycle.
REQ-041 All outputs are registered.

Reset
REQ-042 On prng_reset=1 at a clock edge: state=IDLE, rr_ptr=0, seed_pending=0, range cache invalid, counter=0, and every output is 0.
REQ-043 Reset mid-transaction abandons it: no gnt is issued, and the pending seed is discarded.

Structure
REQ-044 Package prng_pkg holds the FSM state encoding, the default TIMEOUT and the 32-bit data width constant.
REQ-045 One sub-module, rr_arbiter (NUM_REQ-wide request vector plus pointer in, one-hot winner and index out), is purely combinational.

Verification
REQ-046 Reset, then req=0001 with range [0,100): gnt=0001 at cycle 4; rsp_data<100; rng_update_range pulsed once.
REQ-047 Repeat the same request: gnt at cycle 3; no rng_update_range pulse (cache hit).
REQ-048 req=1111 held with four distinct ranges: grants are 0001, 0010, 0100, 1000, 0001, ...; each rsp_data is within its requester's range.
REQ-049 seed_wr with 0xDEADBEEF during WAIT: the current grant completes; the SEED cycle precedes the next RANGE; seed_pending is 1 until then.
REQ-050 Hold rng_valid=0: after 15 WAIT cycles, rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-051 prng_reset asserted in WAIT: no gnt; all outputs 0 next cycle; the next request takes the cache-miss path.
